// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: switch controls in, LED position/image and status out.
interface led_pattern_sequencer_if;
  logic        run;
  logic        clr;
  logic        step;
  logic [1:0]  mode;
  logic [1:0]  speed;
  logic [3:0]  pos;
  logic [15:0] led;
  logic        adv;
  logic        busy;
  modport master(output run, clr, step, mode, speed, input pos, led, adv, busy);
  modport slave(input run, clr, step, mode, speed, output pos, led, adv, busy);
endinterface

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: IDLE/RUN/HOLD waterfall pattern engine with programmable step prescaler.
// Define LED_SEQ_STEP_EN to allow single-step advances from HOLD via the step pulse.
module led_pattern_sequencer #(
  parameter int TICK_DIV = 25_000_000
) (
  input logic                    clk100MHz,
  input logic                    rst_n,
  led_pattern_sequencer_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [3:0]    pos_q, pos_d, nxt_pos;
  logic [15:0]   led_q, led_d, nxt_led;
  logic [1:0]    mode_q, mode_d;
  logic          dir_q, dir_d, nxt_dir;
  logic          adv_q, adv_d, busy_q;
  logic          tick, man_step, do_adv;

  function automatic logic [15:0] onehot(input logic [3:0] p);
    return 16'(1) << p;
  endfunction

  // ">=" lets a speed increase take effect at once instead of wrapping the counter
  assign lim  = CW'((TICK_DIV >> bus.speed) - 1);
  assign tick = state_q == RUN && cnt_q >= lim;
`ifdef LED_SEQ_STEP_EN
  assign man_step = state_q == HOLD && bus.step;
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign man_step    = 1'b0;
`endif
  assign do_adv = tick || man_step;

  // One pattern step; dir_q=1 means moving down in bounce
  always_comb begin
    nxt_dir = dir_q;
    nxt_pos = pos_q + 4'd1;
    if (bus.mode != mode_q) begin
      nxt_dir = 1'b0;
      nxt_pos = bus.mode == 2'b01 ? 4'd15 : 4'd0;
    end else if (mode_q == 2'b01)
      nxt_pos = pos_q - 4'd1;
    else if (mode_q == 2'b10) begin
      nxt_dir = dir_q ? pos_q != 4'd0 : pos_q == 4'd15;
      nxt_pos = nxt_dir ? pos_q - 4'd1 : pos_q + 4'd1;
    end else if (mode_q == 2'b11 && led_q == 16'hFFFF)
      nxt_pos = 4'd0;
    nxt_led = (mode_q == 2'b11 && bus.mode == 2'b11 && led_q != 16'hFFFF) ?
              led_q | onehot(nxt_pos) : onehot(nxt_pos);
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    led_d   = led_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    adv_d   = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      pos_d   = 4'd0;
      led_d   = 16'h0000;
      dir_d   = 1'b0;
      mode_d  = 2'b00;
      cnt_d   = '0;
    end else begin
      if (state_q == IDLE && bus.run) begin
        state_d = RUN;
        pos_d   = bus.mode == 2'b01 ? 4'd15 : 4'd0;
        led_d   = onehot(pos_d);
        dir_d   = 1'b0;
        mode_d  = bus.mode;
        cnt_d   = '0;
      end
      if (state_q == RUN) begin
        cnt_d   = tick ? '0 : bus.run ? cnt_q + CW'(1) : cnt_q;
        state_d = bus.run ? RUN : HOLD;
      end
      if (state_q == HOLD && bus.run) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      if (do_adv) begin
        pos_d  = nxt_pos;
        led_d  = nxt_led;
        dir_d  = nxt_dir;
        mode_d = bus.mode;
        adv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= 4'd0;
      led_q   <= 16'h0000;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      adv_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
      busy_q  <= state_d == RUN;
    end
  end

  assign bus.pos  = pos_q;
  assign bus.led  = led_q;
  assign bus.adv  = adv_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed and random checks against a position/direction pattern model.
module tb_led_pattern_sequencer;
  logic clk100MHz = 1'b0;
  logic rst_n = 1'b0;
  led_pattern_sequencer_if bus();
  led_pattern_sequencer #(.TICK_DIV(8)) dut (.clk100MHz(clk100MHz), .rst_n(rst_n), .bus(bus));
  always #5 clk100MHz = ~clk100MHz;

  int n_chk = 0;
  int n_fail = 0;
  // model: 0 idle, 1 run, 2 hold; led image is derived from pos and applied mode
  int m_st, m_pos, m_mode, m_cnt;
  bit m_up, m_adv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_led();
    if (m_st == 0) return 0;
    return m_mode == 3 ? (2 << m_pos) - 1 : 1 << m_pos;
  endfunction

  task automatic m_reset();
    m_st = 0; m_pos = 0; m_mode = 0; m_cnt = 0; m_up = 1; m_adv = 0;
  endtask

  task automatic advance();
    m_adv = 1;
    if (int'(bus.mode) != m_mode) begin
      m_mode = int'(bus.mode);
      m_pos = m_mode == 1 ? 15 : 0;
      m_up = 1;
    end else if (m_mode == 1) m_pos = (m_pos + 15) % 16;
    else if (m_mode == 2) begin
      if (m_up && m_pos == 15) begin m_up = 0; m_pos = 14; end
      else if (!m_up && m_pos == 0) begin m_up = 1; m_pos = 1; end
      else m_pos = m_up ? m_pos + 1 : m_pos - 1;
    end else m_pos = (m_pos + 1) % 16;
  endtask

  task automatic model_edge();
    int per;
    per = 8 >> int'(bus.speed);
    m_adv = 0;
    if (bus.clr) m_reset();
    else if (m_st == 0) begin
      if (bus.run) begin
        m_st = 1; m_mode = int'(bus.mode); m_pos = m_mode == 1 ? 15 : 0; m_up = 1; m_cnt = 0;
      end
    end else if (m_st == 1) begin
      if (m_cnt >= per - 1) begin advance(); m_cnt = 0; end
      else if (bus.run) m_cnt++;
      if (!bus.run) m_st = 2;
    end else begin
`ifdef LED_SEQ_STEP_EN
      if (bus.step) advance();
`endif
      if (bus.run) begin m_st = 1; m_cnt = 0; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pos"}, 32'(bus.pos), m_pos);
    chk({tag, ".led"}, 32'(bus.led), exp_led());
    chk({tag, ".adv"}, 32'(bus.adv), 32'(m_adv));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_st == 1));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk100MHz);
    #1;
    check_all(tag);
  endtask

  task automatic restart(input logic [1:0] md, input logic [1:0] sp);
    bus.clr = 1; bus.run = 0;
    cycle("clr");
    bus.clr = 0; bus.run = 1; bus.mode = md; bus.speed = sp;
  endtask

  initial begin
    bus.run = 0; bus.clr = 0; bus.step = 0; bus.mode = 0; bus.speed = 0;
    m_reset();
    #12;
    check_all("por");
    rst_n = 1;
    bus.run = 1;
    for (int i = 0; i < 200 && !(m_st == 1 && m_pos == 5); i++) cycle("run5");
    chk("reach5", 32'(bus.pos), 5);
    #2 rst_n = 0;
    #1 m_reset();
    chk("arst.pos", 32'(bus.pos), 0);
    chk("arst.led", 32'(bus.led), 0);
    chk("arst.busy", 32'(bus.busy), 0);
    #3 rst_n = 1;
    cycle("rel");
    chk("rel.led", 32'(bus.led), 32'h0001);
    for (int i = 0; i < 8; i++) cycle("rel8");
    chk("rel8.led", 32'(bus.led), 32'h0002);

    restart(2'b01, 2'd3);
    for (int i = 0; i < 20; i++) cycle("sr");
    restart(2'b10, 2'd3);
    for (int i = 0; i < 34; i++) cycle("bnc");
    restart(2'b11, 2'd3);
    cycle("fill0");
    chk("fill0.led", 32'(bus.led), 32'h0001);
    for (int i = 0; i < 15; i++) cycle("fill");
    chk("fill.full", 32'(bus.led), 32'hFFFF);
    cycle("fill17");
    chk("fill17.led", 32'(bus.led), 32'h0001);

    restart(2'b00, 2'd0);
    for (int i = 0; i < 200 && !(m_st == 1 && m_pos == 7); i++) cycle("run7");
    bus.run = 0;
    for (int i = 0; i < 50; i++) cycle("hold");
    chk("hold.pos", 32'(bus.pos), 7);
    bus.run = 1; bus.mode = 2'b01;
    cycle("resume");
    for (int i = 0; i < 20 && !m_adv; i++) cycle("mchg");
    chk("mchg.pos", 32'(bus.pos), 15);
    for (int i = 0; i < 20 && m_cnt != 7; i++) cycle("pre_clr");
    bus.clr = 1;
    cycle("clr_tick");
    chk("clr_tick.led", 32'(bus.led), 0);
    bus.clr = 0; bus.mode = 2'b00;
    cycle("restart");
    for (int i = 0; i < 200 && !(m_st == 1 && m_pos == 3); i++) cycle("run3");
    bus.run = 0;
    cycle("hold3");
    bus.step = 1;
    cycle("step");
    bus.step = 0;
`ifdef LED_SEQ_STEP_EN
    chk("step.pos", 32'(bus.pos), 4);
`else
    chk("step.pos", 32'(bus.pos), 3);
`endif
    cycle("step_after");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
      bus.clr = $urandom_range(0, 79) == 0;
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 39) == 0) bus.speed = 2'($urandom);
      bus.step = $urandom_range(0, 3) == 0;
      cycle("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
